// File: rtl/stdout_periph.sv
// Cluster stdout device: per-channel character writes tagged and queued in a shared FIFO,
// drained as a ready/valid stream. Define STDOUT_PERIPH_DROP_ON_FULL_EN to drop (not stall) on full.
module stdout_periph #(
  parameter int unsigned NumChannels  = 8,
  parameter int unsigned FifoDepth    = 16,
  parameter int unsigned DropCntWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] add_i,
  input  logic        wen_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic        gnt_o,
  output logic        r_valid_o,
  output logic [31:0] r_rdata_o,
  output logic        r_opc_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic [7:0]  char_data_o,
  output logic [4:0]  char_chan_o
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam int unsigned FW = AW + 1;

  logic [12:0]             mem [FifoDepth];
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [FW-1:0]           fill_q;
  logic [DropCntWidth-1:0] drop_cnt_q;

  logic                    r_valid_q, r_opc_q;
  logic [31:0]             r_rdata_q;

  logic       chan_region, status_hit, chan_ok;
  logic [4:0] chan;
  logic       push_req, full, empty, stall, drop, push, pop, grant;
  logic [31:0] status_word, rdata_d;
  logic        opc_d;

  assign chan_region = (add_i[11:8] == 4'h0);
  assign status_hit  = (add_i[11:0] == 12'hF00);
  assign chan        = add_i[7:3];
  assign chan_ok     = chan_region && (32'(chan) < NumChannels);

  assign full     = (fill_q == FW'(FifoDepth));
  assign empty    = (fill_q == '0);
  assign push_req = req_i && !wen_i && chan_ok && be_i[0];

`ifdef STDOUT_PERIPH_DROP_ON_FULL_EN
  assign stall = 1'b0;
  assign drop  = push_req && full;
`else
  assign stall = push_req && full;
  assign drop  = 1'b0;
`endif

  // Full is judged on the registered fill, so a same-cycle pop never frees room for this write.
  assign push  = push_req && !full;
  assign pop   = !empty && char_ready_i;
  assign grant = req_i && !stall;
  assign gnt_o = grant;

  always_comb begin
    status_word        = '0;
    status_word[31:16] = 16'(drop_cnt_q);
    status_word[15:0]  = 16'(fill_q);
  end

  always_comb begin
    rdata_d = '0;
    opc_d   = 1'b1;
    if (status_hit) begin
      opc_d = 1'b0;
      if (wen_i) rdata_d = status_word;
    end else if (chan_ok && !wen_i) begin
      opc_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_opc_q   <= 1'b0;
    end else begin
      r_valid_q <= grant;
      r_rdata_q <= grant ? rdata_d : '0;
      r_opc_q   <= grant ? opc_d : 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fill_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q] <= {chan, wdata_i[7:0]};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt_q <= '0;
    end else if (grant && status_hit && !wen_i) begin
      drop_cnt_q <= '0;
    end else if (drop && !(&drop_cnt_q)) begin
      drop_cnt_q <= drop_cnt_q + DropCntWidth'(1);
    end
  end

  assign r_valid_o    = r_valid_q;
  assign r_rdata_o    = r_rdata_q;
  assign r_opc_o      = r_opc_q;
  assign char_valid_o = !empty;
  assign char_data_o  = empty ? '0 : mem[rptr_q][7:0];
  assign char_chan_o  = empty ? '0 : mem[rptr_q][12:8];

  logic unused_bits;
  assign unused_bits = ^{add_i[31:12], add_i[2:0], wdata_i[31:8], be_i[3:1]};

endmodule

// File: tb/tb_stdout_periph.sv
// Self-checking bench for stdout_periph: directed steps plus random traffic against a queue model.
module tb_stdout_periph;

  localparam int NCH   = 8;
  localparam int DEPTH = 16;
`ifdef STDOUT_PERIPH_DROP_ON_FULL_EN
  localparam bit DropMode = 1'b1;
`else
  localparam bit DropMode = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic [31:0] add_i;
  logic        wen_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o;
  logic        r_valid_o;
  logic [31:0] r_rdata_o;
  logic        r_opc_o;
  logic        char_valid_o;
  logic        char_ready_i;
  logic [7:0]  char_data_o;
  logic [4:0]  char_chan_o;

  always #5 clk_i = ~clk_i;

  stdout_periph #(
    .NumChannels (NCH),
    .FifoDepth   (DEPTH),
    .DropCntWidth(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .add_i       (add_i),
    .wen_i       (wen_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .gnt_o       (gnt_o),
    .r_valid_o   (r_valid_o),
    .r_rdata_o   (r_rdata_o),
    .r_opc_o     (r_opc_o),
    .char_valid_o(char_valid_o),
    .char_ready_i(char_ready_i),
    .char_data_o (char_data_o),
    .char_chan_o (char_chan_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: queued characters, drop count, response expected next cycle.
  logic [12:0] q[$];
  int          drop_cnt;
  bit          pv;
  logic [31:0] prd;
  bit          popc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit req, input logic [31:0] a, input bit wen,
                       input logic [31:0] wd, input logic [3:0] be, input bit rdy);
    int off, ch;
    bit is_chan, is_stat, ch_ok, pushing, full, eg, ev;
    req_i = req; add_i = a; wen_i = wen; wdata_i = wd; be_i = be; char_ready_i = rdy;
    @(negedge clk_i);
    off     = int'(a[11:0]);
    is_chan = off < 256;
    ch      = (off / 8) % 32;
    is_stat = off == 'hF00;
    ch_ok   = is_chan && ch < NCH;
    pushing = req && !wen && ch_ok && be[0];
    full    = q.size() == DEPTH;
    eg      = req && !(pushing && full && !DropMode);
    ev      = q.size() != 0;
    chk("gnt", 32'(gnt_o), 32'(eg));
    chk("char_valid", 32'(char_valid_o), 32'(ev));
    chk("char_data", 32'(char_data_o), ev ? 32'(q[0][7:0]) : 32'd0);
    chk("char_chan", 32'(char_chan_o), ev ? 32'(q[0][12:8]) : 32'd0);
    chk("r_valid", 32'(r_valid_o), 32'(pv));
    chk("r_rdata", r_rdata_o, prd);
    chk("r_opc", 32'(r_opc_o), 32'(popc));
    pv   = eg;
    prd  = (eg && is_stat && wen) ? {16'(drop_cnt), 16'(q.size())} : 32'd0;
    popc = eg && !(is_stat || (ch_ok && !wen));
    if (ev && rdy) void'(q.pop_front());
    if (eg && is_stat && !wen) drop_cnt = 0;
    if (eg && pushing) begin
      if (!full) q.push_back({5'(ch), wd[7:0]});
      else if (drop_cnt < 65535) drop_cnt++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int ch, input logic [7:0] d, input bit rdy);
    cycle(1'b1, 32'h1A10_4000 | 32'(ch * 8), 1'b0, {24'hABCDEF, d}, 4'hF, rdy);
  endtask
  task automatic st_rd(input bit rdy);
    cycle(1'b1, 32'h1A10_4F00, 1'b1, 32'd0, 4'hF, rdy);
  endtask
  task automatic st_wr(input bit rdy);
    cycle(1'b1, 32'h1A10_4F00, 1'b0, 32'hFFFF_FFFF, 4'hF, rdy);
  endtask
  task automatic idle(input bit rdy);
    cycle(1'b0, 32'd0, 1'b0, 32'd0, 4'h0, rdy);
  endtask

  initial begin
    logic [31:0] a;
    rst_ni = 1'b0; req_i = 1'b0; add_i = '0; wen_i = 1'b0; wdata_i = '0; be_i = '0; char_ready_i = 1'b0;
    drop_cnt = 0; pv = 0; prd = '0; popc = 0;
    repeat (2) @(posedge clk_i);
    #1;
    idle(1'b0);
    rst_ni = 1'b1;
    idle(1'b1);

    // single character on channel 3
    cycle(1'b1, 32'h1A10_4018, 1'b0, 32'h0000_0041, 4'hF, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // fill to the brim with the sink stalled, then push once more
    for (int i = 0; i < 16; i++) wr(i % NCH, 8'(8'h30 + i), 1'b0);
    wr(5, 8'h7A, 1'b0);
    st_rd(1'b0);
    // pop in the same cycle as a write to the full FIFO, then retry
    wr(6, 8'h5B, 1'b1);
    wr(6, 8'h5B, 1'b0);
    st_rd(1'b0);
    st_wr(1'b0);
    st_rd(1'b0);

    // drain
    for (int i = 0; i < 18; i++) idle(1'b1);
    st_rd(1'b1);
    idle(1'b1);

    // decode corners and byte enable
    cycle(1'b1, 32'h1A10_4048, 1'b0, 32'h0000_0055, 4'hF, 1'b0);
    cycle(1'b1, 32'h1A10_4000, 1'b1, 32'd0, 4'hF, 1'b0);
    cycle(1'b1, 32'h1A10_4100, 1'b0, 32'h0000_0066, 4'hF, 1'b0);
    cycle(1'b1, 32'h1A10_4F04, 1'b1, 32'd0, 4'hF, 1'b0);
    cycle(1'b1, 32'h1A10_4010, 1'b0, 32'h0000_0077, 4'b1110, 1'b0);
    st_rd(1'b0);
    idle(1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1: a = 32'h1A10_4000 | ($urandom_range(0, 31) << 3) | $urandom_range(0, 7);
        2:    a = 32'h1A10_4F00;
        default: a = {$urandom_range(0, 32'hFFFFF), 12'h000} | $urandom_range(12'h100, 12'hFFF);
      endcase
      cycle(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 3) == 0), $urandom,
            4'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    // reset with entries queued and a response pending
    for (int i = 0; i < 20; i++) idle(1'b1);
    for (int i = 0; i < 5; i++) wr(i, 8'(8'h61 + i), 1'b0);
    rst_ni = 1'b0;
    req_i  = 1'b0;
    q.delete();
    drop_cnt = 0; pv = 0; prd = '0; popc = 0;
    idle(1'b0);
    rst_ni = 1'b1;
    st_rd(1'b0);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
